// File: rtl/isp_pkg.sv
// Shared definitions for the pixel output path.
//   out_fmt_e  : output pixel format selector (cfg_format_i encoding)
//   C_*        : BT.601 integer coefficients (x256) used by rgb2yuv_core
//   fmt_decode : maps the raw 2-bit format field, reserved code -> RGB pass
package isp_pkg;

  typedef enum logic [1:0] {
    FMT_RGB    = 2'd0,
    FMT_Y      = 2'd1,
    FMT_YUV422 = 2'd2,
    FMT_RSVD   = 2'd3
  } out_fmt_e;

  localparam int C_YR = 77;
  localparam int C_YG = 150;
  localparam int C_YB = 29;
  localparam int C_UR = -43;
  localparam int C_UG = -85;
  localparam int C_UB = 128;
  localparam int C_VR = 128;
  localparam int C_VG = -107;
  localparam int C_VB = -21;

  localparam int C_RND   = 128;
  localparam int C_SHIFT = 8;

  function automatic out_fmt_e fmt_decode(input logic [1:0] f);
    out_fmt_e r;
    if (f == 2'd3) r = FMT_RGB;
    else           r = out_fmt_e'(f);
    return r;
  endfunction

endpackage

// File: rtl/rgb2yuv_core.sv
// Combinational RGB -> YUV (BT.601) conversion with rounding and clamping.
//   rgb_i : {R,G,B}, R in MSBs, PIX_W bits per channel
//   y_o   : luma, clamped to [0, 2^PIX_W-1]
//   u_o   : Cb with 2^(PIX_W-1) offset, clamped
//   v_o   : Cr with 2^(PIX_W-1) offset, clamped
module rgb2yuv_core
  import isp_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [3*PIX_W-1:0] rgb_i,
  output logic [PIX_W-1:0]   y_o,
  output logic [PIX_W-1:0]   u_o,
  output logic [PIX_W-1:0]   v_o
);

  localparam int AW = PIX_W + 10;

  localparam logic signed [AW-1:0] K_YR  = AW'(C_YR);
  localparam logic signed [AW-1:0] K_YG  = AW'(C_YG);
  localparam logic signed [AW-1:0] K_YB  = AW'(C_YB);
  localparam logic signed [AW-1:0] K_UR  = AW'(C_UR);
  localparam logic signed [AW-1:0] K_UG  = AW'(C_UG);
  localparam logic signed [AW-1:0] K_UB  = AW'(C_UB);
  localparam logic signed [AW-1:0] K_VR  = AW'(C_VR);
  localparam logic signed [AW-1:0] K_VG  = AW'(C_VG);
  localparam logic signed [AW-1:0] K_VB  = AW'(C_VB);
  localparam logic signed [AW-1:0] K_RND = AW'(C_RND);
  localparam logic signed [AW-1:0] K_MAX = AW'((1 << PIX_W) - 1);
  localparam logic signed [AW-1:0] K_MID = AW'(1 << (PIX_W - 1));

  logic signed [AW-1:0] w_r, w_g, w_b;
  logic signed [AW-1:0] w_yacc, w_uacc, w_vacc;

  assign w_r = $signed({{(AW-PIX_W){1'b0}}, rgb_i[3*PIX_W-1 -: PIX_W]});
  assign w_g = $signed({{(AW-PIX_W){1'b0}}, rgb_i[2*PIX_W-1 -: PIX_W]});
  assign w_b = $signed({{(AW-PIX_W){1'b0}}, rgb_i[PIX_W-1:0]});

  assign w_yacc = K_YR * w_r + K_YG * w_g + K_YB * w_b;
  assign w_uacc = K_UR * w_r + K_UG * w_g + K_UB * w_b;
  assign w_vacc = K_VR * w_r + K_VG * w_g + K_VB * w_b;

  // Arithmetic shift gives floor division for the negative chroma sums.
  function automatic logic [PIX_W-1:0] round_clamp(
    input logic signed [AW-1:0] acc,
    input logic signed [AW-1:0] ofs
  );
    logic signed [AW-1:0] t;
    logic [PIX_W-1:0]     r;
    t = ((acc + K_RND) >>> C_SHIFT) + ofs;
    if (t < 0)          r = '0;
    else if (t > K_MAX) r = '1;
    else                r = t[PIX_W-1:0];
    return r;
  endfunction

  assign y_o = round_clamp(w_yacc, '0);
  assign u_o = round_clamp(w_uacc, K_MID);
  assign v_o = round_clamp(w_vacc, K_MID);

endmodule

// File: rtl/pixel_out_formatter.sv
// Pixel output formatter: converts an RGB pixel stream to RGB / Y-only /
// YUV422 and tags each pixel with its frame position.
//   clk_i, rst_n_i               : clock, async active-low reset
//   cfg_format_i/width/height    : format and frame geometry, sampled at (0,0)
//   in_data_i/valid/ready/sof    : input pixel stream {R,G,B}
//   out_data_o/valid/ready       : formatted pixel stream
//   out_x_o/out_y_o              : pixel position
//   out_sof_o/eol_o/eof_o        : frame/line markers
//   err_sof_o                    : sticky, sof seen away from (0,0)
module pixel_out_formatter
  import isp_pkg::*;
#(
  parameter  int PIX_W      = 8,
  parameter  int MAX_WIDTH  = 4096,
  parameter  int MAX_HEIGHT = 4096,
  localparam int XW         = $clog2(MAX_WIDTH),
  localparam int YW         = $clog2(MAX_HEIGHT),
  localparam int OUT_W      = 3 * PIX_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       cfg_format_i,
  input  logic [XW-1:0]    cfg_width_i,
  input  logic [YW-1:0]    cfg_height_i,
  input  logic [OUT_W-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_sof_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XW-1:0]    out_x_o,
  output logic [YW-1:0]    out_y_o,
  output logic             out_sof_o,
  output logic             out_eol_o,
  output logic             out_eof_o,
  output logic             err_sof_o
);

  // Position counters and per-frame configuration
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  out_fmt_e      r_fmt;
  logic [XW-1:0] r_wlast;
  logic [YW-1:0] r_hlast;
  logic [PIX_W-1:0] r_vlat;
  logic          r_err;

  // Convert stage
  logic             r_c_valid;
  logic [OUT_W-1:0] r_c_data;
  logic [XW-1:0]    r_c_x;
  logic [YW-1:0]    r_c_y;
  logic             r_c_sof, r_c_eol, r_c_eof;

  // Output stage
  logic             r_o_valid;
  logic [OUT_W-1:0] r_o_data;
  logic [XW-1:0]    r_o_x;
  logic [YW-1:0]    r_o_y;
  logic             r_o_sof, r_o_eol, r_o_eof;

  logic             w_en, w_acc, w_origin, w_eol, w_eof;
  logic [XW-1:0]    w_px, w_wlast;
  logic [YW-1:0]    w_py, w_hlast;
  out_fmt_e         w_fmt;
  logic [PIX_W-1:0] w_luma, w_cb, w_cr;
  logic [OUT_W-1:0] w_cdata;

  assign w_en       = out_ready_i | ~out_valid_o;
  assign in_ready_o = w_en;
  assign w_acc      = in_valid_i & w_en;

  // An sof pixel is forced to (0,0); the frame config is taken live on the
  // origin pixel so that pixel already uses the new settings.
  assign w_origin = in_sof_i | ((r_x == '0) && (r_y == '0));
  assign w_px     = in_sof_i ? '0 : r_x;
  assign w_py     = in_sof_i ? '0 : r_y;
  assign w_fmt    = w_origin ? fmt_decode(cfg_format_i) : r_fmt;
  assign w_wlast  = w_origin ? ((cfg_width_i == '0) ? '0 : cfg_width_i - 1'b1) : r_wlast;
  assign w_hlast  = w_origin ? ((cfg_height_i == '0) ? '0 : cfg_height_i - 1'b1) : r_hlast;
  assign w_eol    = (w_px == w_wlast);
  assign w_eof    = w_eol && (w_py == w_hlast);

  rgb2yuv_core #(
    .PIX_W (PIX_W)
  ) u_conv (
    .rgb_i (in_data_i),
    .y_o   (w_luma),
    .u_o   (w_cb),
    .v_o   (w_cr)
  );

  always_comb begin
    w_cdata = '0;
    case (w_fmt)
      FMT_Y: begin
        w_cdata[PIX_W-1:0] = w_luma;
      end
      FMT_YUV422: begin
        w_cdata[PIX_W-1:0]       = w_luma;
        w_cdata[2*PIX_W-1:PIX_W] = w_px[0] ? r_vlat : w_cb;
      end
      default: begin
        w_cdata = in_data_i;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_fmt   <= FMT_RGB;
      r_wlast <= '0;
      r_hlast <= '0;
      r_vlat  <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= w_eof ? '0 : w_py + 1'b1;
      end else begin
        r_x <= w_px + 1'b1;
        r_y <= w_py;
      end
      if (w_origin) begin
        r_fmt   <= w_fmt;
        r_wlast <= w_wlast;
        r_hlast <= w_hlast;
      end
      // Clearing at end of line keeps an odd-width line's chroma out of
      // the next line.
      if (w_eol)
        r_vlat <= '0;
      else if ((w_fmt == FMT_YUV422) && !w_px[0])
        r_vlat <= w_cr;
      if (in_sof_i && ((r_x != '0) || (r_y != '0)))
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_c_valid <= 1'b0;
      r_c_data  <= '0;
      r_c_x     <= '0;
      r_c_y     <= '0;
      r_c_sof   <= 1'b0;
      r_c_eol   <= 1'b0;
      r_c_eof   <= 1'b0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_x     <= '0;
      r_o_y     <= '0;
      r_o_sof   <= 1'b0;
      r_o_eol   <= 1'b0;
      r_o_eof   <= 1'b0;
    end else if (w_en) begin
      r_c_valid <= in_valid_i;
      if (in_valid_i) begin
        r_c_data <= w_cdata;
        r_c_x    <= w_px;
        r_c_y    <= w_py;
        r_c_sof  <= w_origin;
        r_c_eol  <= w_eol;
        r_c_eof  <= w_eof;
      end
      r_o_valid <= r_c_valid;
      if (r_c_valid) begin
        r_o_data <= r_c_data;
        r_o_x    <= r_c_x;
        r_o_y    <= r_c_y;
        r_o_sof  <= r_c_sof;
        r_o_eol  <= r_c_eol;
        r_o_eof  <= r_c_eof;
      end
    end
  end

  assign out_valid_o = r_o_valid;
  assign out_data_o  = r_o_data;
  assign out_x_o     = r_o_x;
  assign out_y_o     = r_o_y;
  assign out_sof_o   = r_o_sof;
  assign out_eol_o   = r_o_eol;
  assign out_eof_o   = r_o_eof;
  assign err_sof_o   = r_err;

endmodule

// File: tb/tb_pixel_out_formatter.sv
// Self-checking bench for pixel_out_formatter (PIX_W=8).
module tb_pixel_out_formatter;

  localparam int PW = 8;
  localparam int XW = 12;
  localparam int YW = 12;
  localparam int OW = 24;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [1:0]    cfg_format_i;
  logic [XW-1:0] cfg_width_i;
  logic [YW-1:0] cfg_height_i;
  logic [OW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          in_sof_i;
  logic [OW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [XW-1:0] out_x_o;
  logic [YW-1:0] out_y_o;
  logic          out_sof_o, out_eol_o, out_eof_o, err_sof_o;

  always #5 clk_i = ~clk_i;

  pixel_out_formatter #(
    .PIX_W      (PW),
    .MAX_WIDTH  (4096),
    .MAX_HEIGHT (4096)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .cfg_format_i (cfg_format_i),
    .cfg_width_i  (cfg_width_i),
    .cfg_height_i (cfg_height_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_sof_i     (in_sof_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_x_o      (out_x_o),
    .out_y_o      (out_y_o),
    .out_sof_o    (out_sof_o),
    .out_eol_o    (out_eol_o),
    .out_eof_o    (out_eof_o),
    .err_sof_o    (err_sof_o)
  );

  typedef struct {
    logic [OW-1:0] d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof, eol, eof;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [OW-1:0] obs_d[$];
  logic [XW-1:0] obs_x[$];
  logic [YW-1:0] obs_y[$];
  logic          obs_sof[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_eol = 0;
  int n_eof = 0;
  bit stall_mode = 0;
  bit chk_lat = 0;

  // Reference model state: position within frame, frame settings, chroma memory
  int mx = 0, my = 0, mfmt = 0, mw = 1, mh = 1, mV = 0;
  bit merr = 0;

  always @(posedge clk_i) cyc++;

  always @(posedge clk_i) begin
    #1;
    out_ready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fdiv256(input int n);
    int r;
    r = n / 256;
    if (n < 0 && (n % 256) != 0) r = r - 1;
    return r;
  endfunction

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic send(input logic [OW-1:0] d, input bit sof);
    exp_t e;
    int r, g, b, yy, uu, vv, n;
    if (sof) begin
      if (mx != 0 || my != 0) merr = 1;
      mx = 0;
      my = 0;
    end
    if (mx == 0 && my == 0) begin
      mfmt = (cfg_format_i == 2'd3) ? 0 : int'(cfg_format_i);
      mw   = (cfg_width_i == 0) ? 1 : int'(cfg_width_i);
      mh   = (cfg_height_i == 0) ? 1 : int'(cfg_height_i);
    end
    r  = int'(d[23:16]);
    g  = int'(d[15:8]);
    b  = int'(d[7:0]);
    yy = clamp8(fdiv256(77*r + 150*g + 29*b + 128));
    uu = clamp8(fdiv256(-43*r - 85*g + 128*b + 128) + 128);
    vv = clamp8(fdiv256(128*r - 107*g - 21*b + 128) + 128);
    case (mfmt)
      1: e.d = OW'(yy);
      2: begin
        if (mx % 2 == 0) begin
          e.d = OW'(uu * 256 + yy);
          mV  = vv;
        end else begin
          e.d = OW'(mV * 256 + yy);
        end
      end
      default: e.d = d;
    endcase
    e.x   = XW'(mx);
    e.y   = YW'(my);
    e.sof = (mx == 0 && my == 0);
    e.eol = (mx == mw - 1);
    e.eof = e.eol && (my == mh - 1);
    mx++;
    if (mx >= mw) begin
      mx = 0;
      my++;
      if (my >= mh) my = 0;
    end

    in_data_i  = d;
    in_sof_i   = sof;
    in_valid_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    check("in_ready_wait", 64'(in_ready_o), 64'd1);
    e.cyc = cyc;
    q.push_back(e);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    in_sof_i   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid_o) && n < 2000) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard, stall stability, latency
  logic [63:0] prev_bundle, cur_bundle;
  bit hold = 0;
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      hold = 0;
    end else begin
      cur_bundle = 64'({out_valid_o, out_data_o, out_x_o, out_y_o, out_sof_o, out_eol_o, out_eof_o});
      if (hold) check("stall_stable", cur_bundle, prev_bundle);
      if (out_valid_o && out_ready_i) begin
        check("queue_nonempty", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check("data", 64'(out_data_o), 64'(e.d));
          check("sideband", 64'({out_x_o, out_y_o, out_sof_o, out_eol_o, out_eof_o}),
                64'({e.x, e.y, e.sof, e.eol, e.eof}));
          if (chk_lat) check("latency", 64'(cyc), 64'(e.cyc + 2));
        end
        obs_d.push_back(out_data_o);
        obs_x.push_back(out_x_o);
        obs_y.push_back(out_y_o);
        obs_sof.push_back(out_sof_o);
        if (out_eol_o) n_eol++;
        if (out_eof_o) n_eof++;
      end
      hold = out_valid_o && !out_ready_i;
      prev_bundle = cur_bundle;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i      = 1'b0;
    cfg_format_i = 2'd0;
    cfg_width_i  = XW'(4);
    cfg_height_i = YW'(2);
    in_data_i    = '0;
    in_valid_i   = 1'b0;
    in_sof_i     = 1'b0;
    out_ready_i  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_data", 64'(out_data_o), 64'd0);
    check("rst_xy", 64'({out_x_o, out_y_o}), 64'd0);
    check("rst_flags", 64'({out_sof_o, out_eol_o, out_eof_o, err_sof_o}), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd1);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Known conversion points: Y only white, YUV422 white, red then black
    obs_d.delete();
    cfg_format_i = 2'd1; cfg_width_i = XW'(1); cfg_height_i = YW'(1);
    send(24'hFFFFFF, 1);
    cfg_format_i = 2'd2; cfg_width_i = XW'(2); cfg_height_i = YW'(1);
    send(24'hFFFFFF, 1);
    send(24'h000000, 0);
    send(24'hFF0000, 1);
    send(24'h000000, 0);
    drain();
    check("y_white", 64'(obs_d[0]), 64'h0000FF);
    check("yuv_white_even", 64'(obs_d[1]), 64'h0080FF);
    check("yuv_red_even", 64'(obs_d[3]), 64'h00554D);
    check("yuv_black_odd_vclamp", 64'(obs_d[4]), 64'h00FF00);

    // 4x2 frame, no stall: markers and 2-cycle latency
    n_eol = 0; n_eof = 0; chk_lat = 1;
    cfg_format_i = 2'd0; cfg_width_i = XW'(4); cfg_height_i = YW'(2);
    for (int i = 0; i < 8; i++) send(OW'($urandom), i == 0);
    drain();
    chk_lat = 0;
    check("eol_count", 64'(n_eol), 64'd2);
    check("eof_count", 64'(n_eof), 64'd1);

    // Width/height 0 behave as 1
    cfg_format_i = 2'd3; cfg_width_i = '0; cfg_height_i = '0;
    for (int i = 0; i < 3; i++) send(OW'($urandom), i == 0);
    cfg_width_i = '0; cfg_height_i = YW'(2);
    for (int i = 0; i < 4; i++) send(OW'($urandom), i == 0);
    drain();

    // 3 frames of 5x3, random stalls, input gaps, config disturbed mid-frame
    stall_mode = 1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 15; p++) begin
        if (p == 0) begin
          cfg_format_i = (f == 0) ? 2'd2 : ((f == 1) ? 2'd1 : 2'd3);
          cfg_width_i  = XW'(5);
          cfg_height_i = YW'(3);
        end
        send(OW'($urandom), p == 0);
        if (p == 0) begin
          cfg_format_i = 2'($urandom);
          cfg_width_i  = XW'($urandom_range(1, 9));
          cfg_height_i = YW'($urandom_range(1, 9));
        end
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
    drain();
    stall_mode = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check("err_clean", 64'(err_sof_o), 64'(merr));

    // sof at (2,1): sticky error and restart at origin
    obs_d.delete(); obs_x.delete(); obs_y.delete(); obs_sof.delete();
    cfg_format_i = 2'd0; cfg_width_i = XW'(5); cfg_height_i = YW'(3);
    for (int i = 0; i < 7; i++) send(OW'($urandom), i == 0);
    send(OW'($urandom), 1);
    send(OW'($urandom), 0);
    send(OW'($urandom), 0);
    drain();
    check("err_set", 64'(err_sof_o), 64'(merr));
    check("restart_xy", 64'({obs_x[7], obs_y[7], obs_sof[7]}), 64'({12'd0, 12'd0, 1'b1}));
    repeat (5) @(posedge clk_i);
    #1;
    check("err_sticky", 64'(err_sof_o), 64'd1);

    // Reset with two pixels in flight
    send(OW'($urandom), 0);
    send(OW'($urandom), 0);
    rst_n_i = 1'b0;
    q.delete();
    mx = 0; my = 0; mV = 0; merr = 0;
    #1;
    check("rst_mid_valid", 64'(out_valid_o), 64'd0);
    check("rst_mid_ready", 64'(in_ready_o), 64'd1);
    check("rst_mid_err", 64'(err_sof_o), 64'd0);
    @(negedge clk_i);
    check("rst_mid_valid_nc", 64'(out_valid_o), 64'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    obs_d.delete(); obs_x.delete(); obs_y.delete(); obs_sof.delete();
    cfg_format_i = 2'd0; cfg_width_i = XW'(3); cfg_height_i = YW'(2);
    send(OW'($urandom), 0);
    send(OW'($urandom), 0);
    drain();
    check("post_rst_first", 64'({obs_x[0], obs_y[0], obs_sof[0]}), 64'({12'd0, 12'd0, 1'b1}));
    check("post_rst_err", 64'(err_sof_o), 64'(merr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_out_formatter.md
PIXEL_OUT_FORMATTER -- requirements
Module: pixel_out_formatter

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per colour channel (8..12).
REQ-002 SHALL have parameter MAX_WIDTH, default 4096, largest supported line length in pixels.
REQ-003 SHALL have parameter MAX_HEIGHT, default 4096, largest supported frame height in lines.
REQ-004 SHALL have derived widths XW=$clog2(MAX_WIDTH), YW=$clog2(MAX_HEIGHT), OUT_W=3*PIX_W.
REQ-005 clk_i  in  1  clock, all logic on rising edge.
REQ-006 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 cfg_format_i  in  2  0=RGB pass, 1=Y only, 2=YUV422 interleaved, 3=reserved (treated as RGB pass).
REQ-008 cfg_width_i  in  XW  active pixels per line; 0 treated as 1.
REQ-009 cfg_height_i  in  YW  active lines per frame; 0 treated as 1.
REQ-010 in_data_i  in  OUT_W  {R,G,B}, R in MSBs.
REQ-011 in_valid_i / in_ready_o  in / out  1 / 1  input handshake.
REQ-012 in_sof_i  in  1  marks the accepted pixel as pixel (0,0) of a new frame.
REQ-013 out_data_o  out  OUT_W  formatted pixel, unused MSBs zero.
REQ-014 out_valid_o / out_ready_i  out / in  1 / 1  output handshake.
REQ-015 out_x_o / out_y_o  out  XW / YW  position of the pixel on out_data_o.
REQ-016 out_sof_o, out_eol_o, out_eof_o  out  1 each  first pixel of frame, last of line, last of frame.
REQ-017 err_sof_o  out  1  sticky: in_sof_i received while x!=0 or y!=0.

Function
REQ-018 Transfer on either side SHALL occur only when valid and ready are both high in the same cycle.
REQ-019 Pipeline SHALL have two register stages (convert, output); advance enable = out_ready_i | ~out_valid_o; in_ready_o = advance enable.
REQ-020 Latency SHALL be 2 cycles from input transfer to out_valid_o with no stall; no pixel dropped or duplicated under any out_ready_i pattern.
REQ-021 out_data_o and all sideband outputs SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-022 Counters x,y SHALL update per accepted pixel: x wraps to 0 at cfg_width-1, then y increments; y wraps to 0 at cfg_height-1.
REQ-023 Accepted pixel with in_sof_i=1 SHALL be treated as (0,0) and counters restart from it; if counters were not at (0,0), err_sof_o SHALL set.
REQ-024 cfg_format_i, cfg_width_i, cfg_height_i SHALL be sampled on the (0,0) pixel and held for the whole frame.
REQ-025 Y=(77R+150G+29B+128)>>8, U=((-43R-85G+128B+128)>>>8)+2^(PIX_W-1), V=((128R-107G-21B+128)>>>8)+2^(PIX_W-1); signed arithmetic at PIX_W+10 bits, result clamped to [0, 2^PIX_W-1].
REQ-026 RGB pass: out_data_o = in_data_i unchanged.
REQ-027 Y only: out_data_o = {zeros, Y}.
REQ-028 YUV422: even x outputs {zeros, U, Y}; V of the even pixel SHALL be latched; odd x outputs {zeros, Vlatched, Y}.
REQ-029 YUV422 with odd cfg_width: last pixel of line outputs {U,Y}; the V latch SHALL not carry into the next line.
REQ-030 out_eol_o=1 when x=cfg_width-1; out_eof_o=1 when additionally y=cfg_height-1; out_sof_o=1 when x=0 and y=0.

Reset
REQ-031 On rst_n_i low: out_valid_o=0, out_data_o=0, out_x_o=0, out_y_o=0, out_sof_o=0, out_eol_o=0, out_eof_o=0, err_sof_o=0; counters and V latch at 0; latched format=RGB pass.
REQ-032 Reset mid-frame SHALL discard in-flight pixels; the first pixel accepted after reset is (0,0).
REQ-033 in_ready_o SHALL be 1 during and after reset (pipeline empty).
REQ-034 err_sof_o SHALL clear only on reset.

Structure
REQ-035 Shared package isp_pkg SHALL hold the out_fmt_e enum and the BT.601 coefficient constants.
REQ-036 A sub-module rgb2yuv_core SHALL hold the combinational multiply, round and clamp, used by the convert stage.

Verification
REQ-037 PIX_W=8, Y only, RGB (255,255,255) -> out_data_o Y=255; YUV422 even pixel -> U=128.
REQ-038 YUV422, RGB (255,0,0) at x=0 then (0,0,0) at x=1 -> {U=85,Y=77} then {V=255 (clamped),Y=0}.
REQ-039 cfg_width=4, cfg_height=2, 8 pixels, out_ready_i=1 -> eol on x=3 twice; eof only on pixel 8; output 2 cycles after each input.
REQ-040 Random out_ready_i (50%) over 3 frames of 5x3 pixels -> output sequence identical to the no-stall run; data stable during stalls.
REQ-041 in_sof_i at pixel (2,1) -> err_sof_o=1, next outputs restart at (0,0), err_sof_o stays 1.
REQ-042 Reset asserted with 2 pixels in flight -> out_valid_o=0 next cycle; after release the first output has x=0, y=0 and out_sof_o=1.
